// File: rtl/sum_sq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sum_sq_pkg
//  Purpose  : Shared defaults for the sum-of-squares datapath and its lanes.
//  Revision : 1.0 - initial release
// ============================================================================
package sum_sq_pkg;

   // Default component width; lanes and top both take their default from here
   // so a single edit retunes the whole slice.
   localparam int DEFAULT_DIN_W = 16;

endpackage : sum_sq_pkg
`default_nettype wire

// File: rtl/sum_sq_lane.sv
`default_nettype none
// ============================================================================
//  Module   : sq_lane
//  Purpose  : One squaring lane. Takes |x| of a two's-complement sample on
//             load, then squares it with a shift-add multiplier that retires
//             one partial product per step.
//  Revision : 1.0 - initial release
// ============================================================================
module sq_lane
   import sum_sq_pkg::*;
#(
   parameter int DIN_W = DEFAULT_DIN_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_i,
   input  logic                 step_i,
   input  logic [DIN_W-1:0]     sample_i,
   output logic [2*DIN_W-1:0]   sq_o
);

   localparam int PROD_W = 2 * DIN_W;

   logic [DIN_W-1:0]  raw_w;
   logic [DIN_W-1:0]  mag_w;

   logic [PROD_W-1:0] mcand_q, mcand_d;
   logic [DIN_W-1:0]  mplier_q, mplier_d;
   logic [PROD_W-1:0] acc_q, acc_d;

   // Magnitude as an unsigned DIN_W value: the most negative input maps to
   // 2^(DIN_W-1), which still fits, so no saturation is needed.
   assign raw_w = sample_i;
   assign mag_w = raw_w[DIN_W-1] ? (~raw_w + DIN_W'(1)) : raw_w;

   // Next-state for the shift-add square: load seeds both operands with |x|,
   // each step adds the shifted multiplicand when the multiplier LSB is set.
   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      if (load_i) begin
         mcand_d  = {{DIN_W{1'b0}}, mag_w};
         mplier_d = mag_w;
         acc_d    = '0;
      end else if (step_i) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
      end
   end

   // Operand and accumulator registers; reset clears the partial result.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

   assign sq_o = acc_q;

endmodule : sq_lane
`default_nettype wire

// File: rtl/sum_sq.sv
`default_nettype none
// ============================================================================
//  Module   : sum_sq
//  Purpose  : Computes din_i^2 + din_q^2 exactly for an I/Q pair using two
//             parallel shift-add squaring lanes, with valid/ready handshakes
//             on both sides. The result is sized for a square-root stage.
//  Revision : 1.0 - initial release
// ============================================================================
module sum_sq
   import sum_sq_pkg::*;
#(
   parameter int DIN_W  = DEFAULT_DIN_W,
   parameter int DOUT_W = 2 * DIN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIN_W-1:0]  din_i,
   input  logic [DIN_W-1:0]  din_q,
   input  logic              din_valid,
   output logic              din_ready,
   output logic [DOUT_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready
);

   localparam int PROD_W = 2 * DIN_W;
   localparam int CNT_W  = (DIN_W > 1) ? $clog2(DIN_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIN_W - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_SUM  = 2'd2;
   localparam logic [1:0] S_OUT  = 2'd3;

   logic [1:0]        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DOUT_W-1:0] dout_q;
   logic              dout_valid_q;
   logic              din_ready_q;

   logic              load_w;
   logic              step_w;
   logic [PROD_W-1:0] sq_i_w;
   logic [PROD_W-1:0] sq_q_w;

   // Lane enables: capture only on an accepted pair, iterate only in MUL, so
   // din_valid seen in any other state never disturbs the lanes.
   assign load_w = (state_q == S_IDLE) && din_valid;
   assign step_w = (state_q == S_MUL);

   sq_lane #(
      .DIN_W   (DIN_W)
   ) u_lane_i (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load_w),
      .step_i  (step_w),
      .sample_i(din_i),
      .sq_o    (sq_i_w)
   );

   sq_lane #(
      .DIN_W   (DIN_W)
   ) u_lane_q (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load_w),
      .step_i  (step_w),
      .sample_i(din_q),
      .sq_o    (sq_q_w)
   );

   // Control FSM with registered handshake outputs; reset wins over any
   // handshake on the same edge and discards whatever was in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         din_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (din_valid) begin
                  cnt_q       <= '0;
                  din_ready_q <= 1'b0;
                  state_q     <= S_MUL;
               end
            end
            S_MUL: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  state_q <= S_SUM;
               end
            end
            S_SUM: begin
               // Each square is at most 2^(2*DIN_W-2), so the sum fits.
               dout_q       <= DOUT_W'(sq_i_w + sq_q_w);
               dout_valid_q <= 1'b1;
               state_q      <= S_OUT;
            end
            S_OUT: begin
               if (dout_ready) begin
                  dout_valid_q <= 1'b0;
                  din_ready_q  <= 1'b1;
                  state_q      <= S_IDLE;
               end
            end
            default: begin
               state_q      <= S_IDLE;
               dout_valid_q <= 1'b0;
               din_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign din_ready  = din_ready_q;
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;

endmodule : sum_sq
`default_nettype wire

// File: tb/tb_sum_sq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sum_sq
//  Purpose  : Self-checking bench for sum_sq: directed corner pairs, output
//             stall, mid-operation reset, then 1000 random pairs with a
//             floor-sqrt check on every result.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sum_sq;

   localparam int DIN_W  = 16;
   localparam int DOUT_W = 32;

   logic                     clk = 1'b0;
   logic                     rst;
   logic signed [DIN_W-1:0]  din_i;
   logic signed [DIN_W-1:0]  din_q;
   logic                     din_valid;
   logic                     din_ready;
   logic [DOUT_W-1:0]        dout;
   logic                     dout_valid;
   logic                     dout_ready = 1'b0;

   int     total = 0;
   int     bad   = 0;
   longint cyc   = 0;
   longint last_acc = 0;
   longint exp_q[$];
   int     ready_mode = 1;

   sum_sq #(
      .DIN_W     (DIN_W),
      .DOUT_W    (DOUT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .din_i     (din_i),
      .din_q     (din_q),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .dout      (dout),
      .dout_valid(dout_valid),
      .dout_ready(dout_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready: 0 = stall, 1 = always ready, 2 = random back-pressure.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       dout_ready = 1'b0;
         1:       dout_ready = 1'b1;
         default: dout_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   task automatic chk(input string nm, input longint act, input longint expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, expv, expv);
      end
   endtask

   function automatic longint isqrt(input longint v);
      longint lo = 0;
      longint hi = 65536;
      longint mid;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= v) lo = mid;
         else hi = mid - 1;
      end
      return lo;
   endfunction

   task automatic send(input logic signed [DIN_W-1:0] a, input logic signed [DIN_W-1:0] b);
      int n = 0;
      @(negedge clk);
      while (!din_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!din_ready) begin
         chk("din_ready_timeout", longint'(din_ready), 1);
         return;
      end
      din_i     = a;
      din_q     = b;
      din_valid = 1'b1;
      exp_q.push_back(longint'(a) * longint'(a) + longint'(b) * longint'(b));
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      last_acc  = cyc;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", longint'(exp_q.size()), 0);
   endtask

   // Monitor: checks latency on each rising dout_valid and pops the
   // scoreboard on every output handshake.
   initial begin
      bit     prev;
      longint e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 1'b0;
         end else begin
            if (dout_valid && !prev)
               chk("latency", cyc - last_acc, DIN_W + 1);
            if (dout_valid && dout_ready) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_dout_valid", longint'(dout_valid), 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("dout", longint'(dout), e);
                  chk("sqrt", isqrt(longint'(dout)), longint'($floor($sqrt(real'(e)))));
               end
            end
            prev = dout_valid;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      longint a1;
      longint held;
      int     n;
      logic signed [DIN_W-1:0] ra, rb;

      rst       = 1'b1;
      din_valid = 1'b0;
      din_i     = '0;
      din_q     = '0;
      ready_mode = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_din_ready", longint'(din_ready), 1);
      chk("rst_dout", longint'(dout), 0);
      chk("rst_dout_valid", longint'(dout_valid), 0);
      rst = 1'b0;

      // Basic and boundary pairs, plus back-to-back throughput.
      send(16'sd3, 16'sd4);
      wait_drain();
      chk("hold_after_hs", longint'(dout), 25);
      send(-16'sd32768, -16'sd32768);
      a1 = last_acc;
      send(16'sd32767, -16'sd32768);
      chk("throughput", last_acc - a1, DIN_W + 3);
      wait_drain();
      send(16'sd0, 16'sd0);
      wait_drain();

      // Output stall with din_valid pulses that must be ignored.
      ready_mode = 0;
      send(16'sd7, -16'sd9);
      n = 0;
      while (!dout_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("stall_valid_seen", longint'(dout_valid), 1);
      held = longint'(dout);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         din_valid = k[0];
         din_i     = 16'(100 + k);
         din_q     = 16'(200 + k);
         chk("stall_dout", longint'(dout), held);
         chk("stall_dout_valid", longint'(dout_valid), 1);
         chk("stall_din_ready", longint'(din_ready), 0);
      end
      din_valid  = 1'b0;
      ready_mode = 1;
      wait_drain();
      repeat (3) @(posedge clk);
      #1;
      chk("post_stall_idle", longint'(din_ready), 1);
      chk("post_stall_hold", longint'(dout), 130);

      // Reset in the fifth MUL cycle discards the operation.
      send(16'sd1000, 16'sd2000);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_din_ready", longint'(din_ready), 1);
      chk("midrst_dout", longint'(dout), 0);
      chk("midrst_dout_valid", longint'(dout_valid), 0);
      repeat (25) @(posedge clk);
      send(-16'sd5, 16'sd12);
      wait_drain();

      // Random pairs under random back-pressure.
      ready_mode = 2;
      for (int k = 0; k < 1000; k++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         send(ra, rb);
      end
      wait_drain();
      ready_mode = 1;
      repeat (5) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_sum_sq
`default_nettype wire
